// File: rtl/pulse_train_ctrl.sv
// Programmable pulse-train sequencer: `count` pulses, each `width` cycles high in a `period`-cycle slot.
// Optional macro PTC_CONTINUOUS_EN adds a `cont` input that repeats the train until abort.
module pulse_train_ctrl #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef PTC_CONTINUOUS_EN
    input  logic             cont,
`endif
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [NUM_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             pulse_out,
    output logic [NUM_W-1:0] pulse_idx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             start_dly_q, start_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [NUM_W-1:0] count_q, count_d;
    logic [NUM_W-1:0] idx_q, idx_d;
    logic             cont_q, cont_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pulse_q, pulse_d;
    logic             launch;
    logic             fin_err;
    logic             cont_in;

`ifdef PTC_CONTINUOUS_EN
    assign cont_in = cont;
`else
    assign cont_in = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        w_d         = w_q;
        count_d     = count_q;
        idx_d       = idx_q;
        cont_d      = cont_q;
        fin_err     = 1'b0;
        start_dly_d = start;
        launch      = start & ~start_dly_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    period_d = period;
                    count_d  = count;
                    cont_d   = cont_in;
                    cnt_d    = '0;
                    // Width is clamped so every slot keeps at least one low cycle.
                    w_d      = (width >= period) ? period - CNT_W'(1) : width;
                    if (period < CNT_W'(2) || count == '0) begin
                        state_d = FIN;
                        fin_err = 1'b1;
                    end else begin
                        idx_d   = '0;
                        state_d = (w_d != '0) ? HIGH : LOW;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = FIN;
                    fin_err = 1'b1;
                end else begin
                    if (cnt_q == w_q - CNT_W'(1)) begin
                        state_d = LOW;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = FIN;
                    fin_err = 1'b1;
                end else if (cnt_q == period_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (idx_q == count_q - NUM_W'(1)) begin
                        if (cont_q) begin
                            idx_d   = '0;
                            state_d = (w_q != '0) ? HIGH : LOW;
                        end else begin
                            state_d = FIN;
                        end
                    end else begin
                        idx_d   = idx_q + NUM_W'(1);
                        state_d = (w_q != '0) ? HIGH : LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == HIGH) || (state_d == LOW);
        pulse_d = (state_d == HIGH);
        done_d  = (state_d == FIN);
        err_d   = fin_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_dly_q <= 1'b0;
            cnt_q       <= '0;
            period_q    <= '0;
            w_q         <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            cont_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= start_dly_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            w_q         <= w_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            cont_q      <= cont_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pulse_q     <= pulse_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pulse_out = pulse_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Directed testbench for pulse_train_ctrl; sample j is taken 1 time unit after the j-th edge following launch.
// Define PTC_CONTINUOUS_EN to also exercise continuous mode.
module tb_pulse_train_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
`ifdef PTC_CONTINUOUS_EN
    logic        cont;
`endif
    logic [15:0] period;
    logic [15:0] width;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic        err;
    logic        pulse_out;
    logic [7:0]  pulse_idx;

    int errors = 0;
    int checks = 0;

    pulse_train_ctrl #(.CNT_W(16), .NUM_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
`ifdef PTC_CONTINUOUS_EN
        .cont      (cont),
`endif
        .period    (period),
        .width     (width),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pulse_out (pulse_out),
        .pulse_idx (pulse_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves start low for one edge so the FSM is idle and the next start=1 is a fresh edge.
    task automatic prep(input logic [15:0] p, input logic [15:0] w, input logic [7:0] c);
        start = 1'b0;
        step();
        period = p;
        width  = w;
        count  = c;
        start  = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        period = 16'd0; width = 16'd0; count = 8'd0;
`ifdef PTC_CONTINUOUS_EN
        cont = 1'b0;
`endif
        step();
        step();
        obs = {busy, pulse_out, done, err, pulse_idx};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 12'h000);
        end
        rst = 1'b0;
        step();
        obs = {busy, pulse_out, done, err, pulse_idx};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", obs, 12'h000);
        end
    endtask

    task automatic test_basic();
        logic [11:0] obs, exp;
        prep(16'd5, 16'd2, 8'd3);
        for (int j = 1; j <= 16; j++) begin
            step();
            start = 1'b0;
            if (j <= 15) exp = {1'b1, ((j - 1) % 5) < 2, 1'b0, 1'b0, 8'((j - 1) / 5)};
            else         exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL basic j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
    endtask

    task automatic test_width_edges();
        logic [11:0] obs, exp;
        prep(16'd4, 16'd0, 8'd2);
        for (int j = 1; j <= 9; j++) begin
            step();
            start = 1'b0;
            if (j <= 8) exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'((j - 1) / 4)};
            else        exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL width0 j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
        prep(16'd4, 16'd9, 8'd1);
        for (int j = 1; j <= 5; j++) begin
            step();
            start = 1'b0;
            if (j <= 4) exp = {1'b1, j <= 3, 1'b0, 1'b0, 8'd0};
            else        exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL width_clamp j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
    endtask

    task automatic test_config_error();
        logic [11:0] obs, exp;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) prep(16'd1, 16'd1, 8'd3);
            else        prep(16'd5, 16'd2, 8'd0);
            for (int j = 1; j <= 2; j++) begin
                step();
                start = 1'b0;
                exp = (j == 1) ? {1'b0, 1'b0, 1'b1, 1'b1, 8'd0} : 12'h000;
                obs = {busy, pulse_out, done, err, pulse_idx};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL cfg_err k=%0d j=%0d got=%h exp=%h", k, j, obs, exp);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [11:0] obs, exp;
        // Abort coincides with launch in IDLE: the launch must still proceed.
        prep(16'd6, 16'd3, 8'd4);
        abort = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            start = 1'b0;
            abort = (j == 8);
            if (j <= 8)       exp = {1'b1, ((j - 1) % 6) < 3, 1'b0, 1'b0, 8'((j - 1) / 6)};
            else if (j == 9)  exp = {1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
            else              exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
        prep(16'd3, 16'd1, 8'd1);
        for (int j = 1; j <= 4; j++) begin
            step();
            start = 1'b0;
            if (j <= 3) exp = {1'b1, j == 1, 1'b0, 1'b0, 8'd0};
            else        exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL after_abort j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] obs, exp;
        // start held high through and past the end of the train
        prep(16'd2, 16'd1, 8'd1);
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 1)      exp = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
            else if (j == 2) exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
            else if (j == 3) exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
            else             exp = 12'h000;
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL held_start j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
        // fresh 0->1 edge while busy must be ignored
        prep(16'd4, 16'd2, 8'd2);
        for (int j = 1; j <= 11; j++) begin
            step();
            start = (j >= 2);
            if (j <= 8)      exp = {1'b1, ((j - 1) % 4) < 2, 1'b0, 1'b0, 8'((j - 1) / 4)};
            else if (j == 9) exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
            else             exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL busy_edge j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
        // reset in the middle of a HIGH phase
        prep(16'd4, 16'd3, 8'd2);
        for (int j = 1; j <= 8; j++) begin
            step();
            start = 1'b0;
            rst   = (j == 1);
            exp = (j == 1) ? {1'b1, 1'b1, 1'b0, 1'b0, 8'd0} : 12'h000;
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_reset j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
    endtask

    task automatic test_max_count();
        logic [11:0] obs, exp;
        prep(16'd2, 16'd1, 8'd255);
        for (int j = 1; j <= 511; j++) begin
            step();
            start = 1'b0;
            if (j <= 510) exp = {1'b1, ((j - 1) % 2) == 0, 1'b0, 1'b0, 8'((j - 1) / 2)};
            else          exp = {1'b0, 1'b0, 1'b1, 1'b0, 8'd254};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL max_count j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
    endtask

`ifdef PTC_CONTINUOUS_EN
    task automatic test_continuous();
        logic [11:0] obs, exp;
        prep(16'd3, 16'd1, 8'd2);
        cont = 1'b1;
        for (int j = 1; j <= 26; j++) begin
            step();
            start = 1'b0;
            cont  = 1'b0;
            abort = (j == 24);
            if (j <= 24)      exp = {1'b1, ((j - 1) % 3) == 0, 1'b0, 1'b0, 8'(((j - 1) / 3) % 2)};
            else if (j == 25) exp = {1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
            else              exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
            obs = {busy, pulse_out, done, err, pulse_idx};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL continuous j=%0d got=%h exp=%h", j, obs, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_width_edges();
        test_config_error();
        test_abort();
        test_back_to_back();
        test_max_count();
`ifdef PTC_CONTINUOUS_EN
        test_continuous();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
